// File: rtl/crc5_frame_ctl.sv
// CRC-5 (x^5+x^3+1, preset 01001) framing sequencer for PIE-decoded reader commands.
// Define CRC5_CMD_FILTER_EN to add the leading command-code compare behind cmdok.
module crc5_frame_ctl #(
    parameter int                  FRAME_BITS = 22,
    parameter int                  CMD_BITS   = 4,
    parameter logic [CMD_BITS-1:0] CMD_CODE   = 4'b1000
) (
    input  logic       crcinclk,
    input  logic       reset,
    input  logic       bitin,
    input  logic       bitvalid,
    input  logic       framestart,
    input  logic       frameabort,
    output logic [4:0] crc,
    output logic [4:0] bitcount,
    output logic       busy,
    output logic       done,
    output logic       crcok,
    output logic       cmdok
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [4:0] CRC_PRESET = 5'b01001;
    localparam logic [4:0] LAST_BIT   = 5'(FRAME_BITS);

    if (FRAME_BITS < 6 || FRAME_BITS > 31 || CMD_BITS < 1 ||
        CMD_BITS > FRAME_BITS - 5 || $bits(CMD_CODE) != CMD_BITS) begin : g_param_check
        $error("crc5_frame_ctl: illegal parameter set");
    end

    function automatic logic [4:0] crc_step(input logic [4:0] c, input logic b);
        logic fb;
        fb = b ^ c[4];
        return {c[3], c[2] ^ fb, c[1], c[0], fb};
    endfunction

    state_t     state, state_n;
    logic [4:0] crc_n, bitcount_n;
    logic       crcok_n, cmdok_n;
    logic       start, accept, complete;
    logic [4:0] stepped, cnt_inc;

`ifdef CRC5_CMD_FILTER_EN
    logic mismatch, mismatch_n;
    logic code_bit, in_cmd, bit_miss;

    // Expected code bit for the position this edge would accept, MSB first.
    always_comb begin
        code_bit = 1'b0;
        in_cmd   = 1'b0;
        for (int i = 0; i < CMD_BITS; i++) begin
            if (cnt_inc == 5'(i + 1)) begin
                in_cmd   = 1'b1;
                code_bit = CMD_CODE[CMD_BITS-1-i];
            end
        end
        bit_miss = in_cmd & (bitin != code_bit);
    end
`endif

    // bitvalid qualifies bitin on each rising edge; there is no backpressure,
    // so every valid bit seen in SHIFT (or with framestart) is consumed that edge.
    assign start   = bitvalid & framestart;
    assign stepped = crc_step(start ? CRC_PRESET : crc, bitin);
    assign cnt_inc = start ? 5'd1 : bitcount + 5'd1;

    always_comb begin
        state_n    = state;
        crc_n      = crc;
        bitcount_n = bitcount;
        crcok_n    = crcok;
        cmdok_n    = cmdok;
        accept     = 1'b0;
        complete   = 1'b0;
`ifdef CRC5_CMD_FILTER_EN
        mismatch_n = mismatch;
`endif
        case (state)
            IDLE, DONE: begin
                state_n = IDLE;
                if (start) begin
                    state_n = SHIFT;
                    accept  = 1'b1;
                end
            end
            SHIFT: begin
                // Abort wins over any bit or restart on the same edge.
                if (frameabort) begin
                    state_n    = IDLE;
                    bitcount_n = 5'd0;
                end else if (bitvalid) begin
                    accept = 1'b1;
                    if (!start && cnt_inc == LAST_BIT) begin
                        state_n  = DONE;
                        complete = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (accept) begin
            crc_n      = stepped;
            bitcount_n = cnt_inc;
`ifdef CRC5_CMD_FILTER_EN
            mismatch_n = (start ? 1'b0 : mismatch) | bit_miss;
`endif
            if (start) begin
                crcok_n = 1'b0;
                cmdok_n = 1'b0;
            end
        end

        if (complete) begin
            crcok_n = (stepped == 5'd0);
`ifdef CRC5_CMD_FILTER_EN
            cmdok_n = ~mismatch_n;
`else
            cmdok_n = 1'b1;
`endif
        end
    end

    always_ff @(posedge crcinclk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            crc      <= CRC_PRESET;
            bitcount <= 5'd0;
            crcok    <= 1'b0;
            cmdok    <= 1'b0;
`ifdef CRC5_CMD_FILTER_EN
            mismatch <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            crc      <= crc_n;
            bitcount <= bitcount_n;
            crcok    <= crcok_n;
            cmdok    <= cmdok_n;
`ifdef CRC5_CMD_FILTER_EN
            mismatch <= mismatch_n;
`endif
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_crc5_frame_ctl.sv
// Bench for crc5_frame_ctl: frame vector table plus hand sequences for abort,
// restart, back-to-back and async reset; done results go through an expected queue.
module tb_crc5_frame_ctl;

    localparam int FB = 22;
    localparam logic [31:0] GQ  = 32'h0020_0010;
    localparam logic [31:0] BAD = 32'h0020_0011;

    logic       crcinclk = 1'b0;
    logic       reset, bitin, bitvalid, framestart, frameabort;
    logic [4:0] crc, bitcount;
    logic       busy, done, crcok, cmdok;

    int         nvec = 0;
    int         nfail = 0;
    logic [6:0] exp_q[$];

    typedef struct {
        logic [31:0] bits;
        int          gap;
        logic [4:0]  exp_crc;
        logic        exp_crcok;
        logic        exp_cmdok;
    } vec_t;

    vec_t vecs[8];

    crc5_frame_ctl dut (
        .crcinclk  (crcinclk),
        .reset     (reset),
        .bitin     (bitin),
        .bitvalid  (bitvalid),
        .framestart(framestart),
        .frameabort(frameabort),
        .crc       (crc),
        .bitcount  (bitcount),
        .busy      (busy),
        .done      (done),
        .crcok     (crcok),
        .cmdok     (cmdok)
    );

    // clock / watchdog
    always #5 crcinclk = ~crcinclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // reference model
    function automatic logic [4:0] crc_of(input logic [31:0] bits, input int n);
        logic [4:0] c;
        logic       fb;
        c = 5'b01001;
        for (int i = n - 1; i >= 0; i--) begin
            fb = bits[i] ^ c[4];
            c  = {c[3], c[2] ^ fb, c[1], c[0], fb};
        end
        return c;
    endfunction

    function automatic logic cmd_exp(input logic [31:0] f);
`ifdef CRC5_CMD_FILTER_EN
        return f[FB-1 -: 4] == 4'b1000;
`else
        return (f[0] | 1'b1);
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver tasks: inputs change on the falling edge
    task automatic cycle(input logic v, input logic b, input logic fs, input logic fa);
        @(negedge crcinclk);
        bitvalid   = v;
        bitin      = b;
        framestart = fs;
        frameabort = fa;
    endtask

    task automatic send_frame(input logic [31:0] f, input int gap);
        for (int i = 0; i < FB; i++) begin
            cycle(1'b1, f[FB-1-i], i == 0, 1'b0);
            if (i < FB - 1) repeat (gap) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic check_done_pulse(input string tag);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk({tag, "_done_latency"}, 32'(done), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk({tag, "_done_width"}, 32'(done), 32'd0);
    endtask

    // scoreboard: every done pulse pops one expected result
    always @(negedge crcinclk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                logic [6:0] e;
                e = exp_q.pop_front();
                chk("done_crc", 32'(crc), 32'(e[6:2]));
                chk("done_crcok", 32'(crcok), 32'(e[1]));
                chk("done_cmdok", 32'(cmdok), 32'(e[0]));
                chk("done_bitcount", 32'(bitcount), 32'(FB));
            end
        end
    end

    initial begin
        logic [31:0] f;
        logic [16:0] d;

        reset = 1'b0; bitin = 1'b0; bitvalid = 1'b0; framestart = 1'b0; frameabort = 1'b0;
        #1 reset = 1'b1;
        #2;
        chk("rst_crc", 32'(crc), 32'h09);
        chk("rst_bitcount", 32'(bitcount), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_crcok", 32'(crcok), 32'd0);
        chk("rst_cmdok", 32'(cmdok), 32'd0);
        @(negedge crcinclk);
        @(negedge crcinclk);
        reset = 1'b0;

        // good Query with intermediate register check after bit 17
        for (int i = 0; i < FB; i++) begin
            cycle(1'b1, GQ[FB-1-i], i == 0, 1'b0);
            if (i == 17) begin
                chk("gq_crc_bit17", 32'(crc), 32'h10);
                chk("gq_bitcount_bit17", 32'(bitcount), 32'd17);
                chk("gq_busy", 32'(busy), 32'd1);
            end
        end
        exp_q.push_back({5'b00000, 1'b1, cmd_exp(GQ)});
        check_done_pulse("gq");
        chk("gq_busy_idle", 32'(busy), 32'd0);
        chk("gq_crcok_held", 32'(crcok), 32'd1);

        // vector table
        vecs[0] = '{GQ, 0, 5'b00000, 1'b1, cmd_exp(GQ)};
        vecs[1] = '{BAD, 0, 5'b01001, 1'b0, cmd_exp(BAD)};
        vecs[2] = '{GQ, 3, 5'b00000, 1'b1, cmd_exp(GQ)};
        d = 17'h12000;
        f = ({15'b0, d} << 5) | 32'(crc_of({15'b0, d}, 17));
        vecs[3] = '{f, 1, 5'b00000, 1'b1, cmd_exp(f)};
        for (int k = 4; k < 8; k++) begin
            d = 17'($urandom_range(0, 17'h1ffff));
            if (k % 2 == 0) d[16:13] = 4'b1000;
            f = ({15'b0, d} << 5) | 32'(crc_of({15'b0, d}, 17));
            if (k >= 6) f = f ^ (32'd1 << $urandom_range(0, FB - 1));
            vecs[k] = '{f, $urandom_range(0, 2), crc_of(f, FB), crc_of(f, FB) == 5'd0, cmd_exp(f)};
        end
        for (int v = 0; v < 8; v++) begin
            send_frame(vecs[v].bits, vecs[v].gap);
            exp_q.push_back({vecs[v].exp_crc, vecs[v].exp_crcok, vecs[v].exp_cmdok});
            check_done_pulse("vec");
        end

        // back-to-back: second frame starts in the DONE cycle
        send_frame(GQ, 0);
        exp_q.push_back({5'b00000, 1'b1, cmd_exp(GQ)});
        send_frame(BAD, 0);
        exp_q.push_back({5'b01001, 1'b0, cmd_exp(BAD)});
        check_done_pulse("b2b");

        // abort after bit 10, with bitvalid on the abort edge
        for (int i = 0; i < 10; i++) cycle(1'b1, GQ[FB-1-i], i == 0, 1'b0);
        cycle(1'b1, GQ[FB-11], 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_bitcount", 32'(bitcount), 32'd0);
        chk("abort_crc_kept", 32'(crc), 32'h05);
        repeat (4) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("abort_no_done", 32'(done), 32'd0);

        // restart at bit 12 of a junk frame, then a full good frame
        for (int i = 0; i < 11; i++) cycle(1'b1, 1'($urandom_range(0, 1)), i == 0, 1'b0);
        for (int i = 0; i < FB; i++) begin
            cycle(1'b1, GQ[FB-1-i], i == 0, 1'b0);
            if (i == 1) chk("restart_bitcount", 32'(bitcount), 32'd1);
        end
        exp_q.push_back({5'b00000, 1'b1, cmd_exp(GQ)});
        check_done_pulse("restart");

        // frameabort in IDLE does not block a frame start
        for (int i = 0; i < FB; i++) begin
            cycle(1'b1, GQ[FB-1-i], i == 0, i == 0);
            if (i == 1) chk("idle_abort_bitcount", 32'(bitcount), 32'd1);
        end
        exp_q.push_back({5'b00000, 1'b1, cmd_exp(GQ)});
        check_done_pulse("idle_abort");

        // asynchronous reset mid-frame, checked before any clock edge
        for (int i = 0; i < 9; i++) cycle(1'b1, GQ[FB-1-i], i == 0, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("midrst_crc", 32'(crc), 32'h09);
        chk("midrst_bitcount", 32'(bitcount), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_crcok", 32'(crcok), 32'd0);
        chk("midrst_cmdok", 32'(cmdok), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("midrst_busy_after", 32'(busy), 32'd0);
        chk("midrst_no_done", 32'(done), 32'd0);

        chk("pending_done", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
